// File: rtl/regfile_mp.sv
// Multi-ported register file with write-to-read bypass and a per-register busy scoreboard.
// Storage has no reset; an INIT sweep writes zeros one entry per cycle after reset or clr.
module regfile_mp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NREAD  = 2,
   parameter int unsigned NWRITE = 2,
   parameter bit          BYPASS = 1'b1,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     clr,
   input  logic [NWRITE-1:0]        wen,
   input  logic [NWRITE*AW-1:0]     wsel,
   input  logic [NWRITE*DATA_W-1:0] wdat,
   input  logic [NREAD*AW-1:0]      rsel,
   output logic [NREAD*DATA_W-1:0]  rdat,
   output logic [NREAD-1:0]         rbusy,
   input  logic                     claim,
   input  logic [AW-1:0]            csel,
   output logic                     ready
);

   localparam logic [0:0] StInit = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]        r_state;
   logic [AW-1:0]     r_idx;
   logic [DATA_W-1:0] r_mem [NREGS];
   logic [NREGS-1:0]  r_busy;
   logic [NREGS-1:0]  w_busy_d;
   logic              w_run_wr;
   logic [AW-1:0]     w_sel;
   logic [DATA_W-1:0] w_val;

   assign ready    = (r_state == StRun);
   // A clr cycle discards its writes and claims.
   assign w_run_wr = (r_state == StRun) && !clr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= StInit;
         r_idx   <= '0;
      end else if (r_state == StInit) begin
         r_idx <= r_idx + AW'(1);
         if (r_idx == AW'(NREGS - 1)) begin
            r_state <= StRun;
         end
      end else if (clr) begin
         r_state <= StInit;
         r_idx   <= '0;
      end
   end

   // Ascending port order so the highest-numbered writer lands last.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (r_state == StInit) begin
            r_mem[r_idx] <= '0;
         end else if (w_run_wr) begin
            for (int p = 0; p < int'(NWRITE); p++) begin
               if (wen[p] && (wsel[p*AW +: AW] != '0)) begin
                  r_mem[wsel[p*AW +: AW]] <= wdat[p*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   always_comb begin
      w_busy_d = r_busy;
      if (!w_run_wr) begin
         w_busy_d = '0;
      end else begin
         for (int p = 0; p < int'(NWRITE); p++) begin
            if (wen[p]) begin
               w_busy_d[wsel[p*AW +: AW]] = 1'b0;
            end
         end
         if (claim) begin
            w_busy_d[csel] = 1'b1;
         end
      end
      w_busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_d;
      end
   end

   always_comb begin
      rdat  = '0;
      rbusy = '0;
      w_sel = '0;
      w_val = '0;
      for (int i = 0; i < int'(NREAD); i++) begin
         w_sel = rsel[i*AW +: AW];
         w_val = '0;
         if ((r_state == StRun) && (w_sel != '0)) begin
            w_val = r_mem[w_sel];
            if (BYPASS && !clr) begin
               for (int p = 0; p < int'(NWRITE); p++) begin
                  if (wen[p] && (wsel[p*AW +: AW] == w_sel)) begin
                     w_val = wdat[p*DATA_W +: DATA_W];
                  end
               end
            end
            rbusy[i] = r_busy[w_sel];
         end
         rdat[i*DATA_W +: DATA_W] = w_val;
      end
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-ported register file for the pipelined and multi-core datapaths. It provides NREAD combinational read ports and NWRITE write ports with same-cycle write-to-read bypass. A per-register busy scoreboard supports hazard detection. After reset or a `clr` request, a sweep sequencer zeroes the storage one entry per cycle, so the array maps onto RAM-style storage without a global reset.

## Interface
Parameters:
- DATA_W, 32, word width
- NREGS, 32, register count (power of two, ≥4); AW = log2(NREGS)
- NREAD, 2, read ports
- NWRITE, 2, write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- clr  in  1  request a storage sweep (level, sampled in RUN)
- wen  in  NWRITE  per-port write enable
- wsel  in  NWRITE×AW  write index per port
- wdat  in  NWRITE×DATA_W  write data per port
- rsel  in  NREAD×AW  read index per port
- rdat  out  NREAD×DATA_W  read data per port (combinational)
- rbusy  out  NREAD  busy bit of rsel[i]
- claim  in  1  mark register csel busy (producer issued)
- csel  in  AW  index to claim
- ready  out  1  high when in RUN

## Operation
- States: INIT (sweep), RUN.
- RST=1 at an edge: state←INIT, idx←0, all busy←0. Storage is not reset directly.
- INIT: each cycle writes 0 to entry idx and increments idx. When idx = NREGS−1 is written, state←RUN. wen, claim and clr are ignored. rdat=0, rbusy=0 and ready=0.
- RUN with clr=1: state←INIT, idx←0, busy←0. Writes and claims in that cycle are discarded.
- Entry 0 reads as 0 at all times. Writes, claims and busy on index 0 are ignored (busy[0]=0).
- Multiple wen to the same index in one cycle: highest port number wins.
- Read: rdat[i] = storage[rsel[i]]. If BYPASS=1 and an enabled write in the same cycle targets rsel[i]≠0, rdat[i] is that write's data (highest port wins). BYPASS=0: the old value is returned until the edge.
- Scoreboard: a write to index k clears busy[k] at the edge. claim sets busy[csel] at the edge. If claim and write hit the same index in one cycle, claim wins (busy stays 1).
- rbusy[i] = busy[rsel[i]] (registered value; no bypass of a same-cycle claim or clear).

## Timing
- Reset values: ready=0, rbusy=0, rdat=0. The state after reset is INIT.
- RST deasserted after edge E0: edges E1…E_NREGS clear entries 0…NREGS−1. ready=1 from E_NREGS onward, a latency of NREGS cycles. The clr sweep has the same latency.
- RST asserted mid-sweep restarts the sweep at idx 0.
- Write latency: data written at edge E is visible on a non-bypassed read after E. With BYPASS=1 it is visible combinationally in the same cycle.
- Read latency: 0 cycles (combinational from rsel, storage and write ports).
- Claim-to-busy: 1 edge.

## Test plan
- Reset: RST=1 for 1 cycle, then 0. Expect ready=0 for exactly 32 cycles, then 1. All rdat=0 and rbusy=0 afterwards, including after pre-loading junk before reset.
- Write/read: port0 writes 0xDEADBEEF to r5. Next cycle rsel0=5 returns 0xDEADBEEF. A write of 0x1234 to r0 leaves r0 reading 0.
- Bypass and conflict: in one cycle, port0 writes 0xAAAA0000 and port1 writes 0x5555FFFF to r7, with rsel1=7. Expect rdat1=0x5555FFFF in that cycle and stored. With BYPASS=0, rdat1 shows the old value in that cycle.
- Scoreboard: claim r9, then rbusy for r9 is 1 the next cycle. A write to r9 clears it after the edge. Claim and write to r9 in the same cycle leave busy=1. Claim r0 leaves busy 0.
- clr mid-operation: in RUN with r3=0x42 and r3 busy, assert clr together with a write of 0x99 to r4. Expect ready=0 for 32 cycles, then r3=0, r4=0 and busy cleared.
- Reset mid-sweep: RST at sweep cycle 10. Expect ready to rise 32 cycles after the new reset and all entries to read 0.
